// File: rtl/between_link_pkg.sv
// between_link_pkg: shared FSM states, CRC-8 constants and error bit indices for the between-link
package between_link_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_CRC, S_WAIT_RDY, S_SEND, S_DONE} state_e;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int ERR_RDY_TO = 0;
  localparam int ERR_CAP_TO = 1;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: one-bit-per-cycle CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection)
// ports: clk, reset (async active-low), clr_i (sync clear, wins over en_i),
//        en_i (shift bit_i in this cycle), bit_i (serial data), crc_o (running CRC)
module crc8_serial
  import between_link_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) crc_o <= CRC8_INIT;
    else if (clr_i) crc_o <= CRC8_INIT;
    else if (en_i) crc_o <= crc8_step(crc_o, bit_i);
endmodule

// File: rtl/fifo_to_between.sv
// fifo_to_between: pops bytes from a FIFO, CRCs them serially and hands them over the tsent/trecieve link
// ports: clk, reset (async active-low), enable (freeze when 0), crc_clear (IDLE only),
//        fifo_empty/fifo_data/fifo_re (source FIFO), t0..t7 (byte, t0 = MSB), tsent/trecieve (handshake),
//        CRC (running CRC-8), byte_count (completed bytes, wraps), isFinish (completion pulse),
//        error (sticky: [0] ready timeout, [1] capture timeout)
module fifo_to_between
  import between_link_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             crc_clear,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_re,
  output logic             t0,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             t4,
  output logic             t5,
  output logic             t6,
  output logic             t7,
  output logic             tsent,
  input  logic             trecieve,
  output logic [7:0]       CRC,
  output logic [CNT_W-1:0] byte_count,
  output logic             isFinish,
  output logic [3:0]       error
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       sync_q;
  logic             re_q, re_d, tsent_q, tsent_d, fin_q, fin_d;
  logic             rdy, tmo;
  assign rdy = sync_q[1];
  assign tmo = tmr_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tsent_d = tsent_q;
    re_d    = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tsent_d = 1'b0;
        if (crc_clear) begin
          cnt_d = '0;
          err_d = '0;
        end
        if (!fifo_empty) begin
          state_d = S_READ;
          re_d    = 1'b1;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        byte_d  = fifo_data;
        idx_d   = 3'd7;
        state_d = S_CRC;
      end
      S_CRC: begin
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          state_d = S_WAIT_RDY;
          tmr_d   = '0;
        end
      end
      S_WAIT_RDY:
        if (rdy) begin
          state_d = S_SEND;
          tsent_d = 1'b1;
          tmr_d   = '0;
        end else if (tmo) begin
          state_d           = S_IDLE;
          err_d[ERR_RDY_TO] = 1'b1;
        end else tmr_d = tmr_q + 1'b1;
      S_SEND:
        if (!rdy) begin
          state_d = S_DONE;
          tsent_d = 1'b0;
          fin_d   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else if (tmo) begin
          state_d           = S_IDLE;
          tsent_d           = 1'b0;
          err_d[ERR_CAP_TO] = 1'b1;
        end else tmr_d = tmr_q + 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // enable gates every register, synchronizer included, so a stall resumes cycle-exact
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      sync_q  <= '0;
      re_q    <= 1'b0;
      tsent_q <= 1'b0;
      fin_q   <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sync_q  <= {sync_q[0], trecieve};
      re_q    <= re_d;
      tsent_q <= tsent_d;
      fin_q   <= fin_d;
    end
  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .en_i  (enable && state_q == S_CRC),
    .clr_i (enable && state_q == S_IDLE && crc_clear),
    .bit_i (byte_q[idx_q]),
    .crc_o (CRC)
  );
  assign {t0, t1, t2, t3, t4, t5, t6, t7} = byte_q;
  assign fifo_re    = re_q;
  assign tsent      = tsent_q;
  assign isFinish   = fin_q;
  assign byte_count = cnt_q;
  assign error      = {2'b00, err_q};
endmodule

// File: tb/tb_fifo_to_between.sv
// tb_fifo_to_between: randomized self-checking bench with a bytewise CRC/handshake reference model
module tb_fifo_to_between;
  logic       clk = 0, reset = 0, enable = 1, crc_clear = 0, fifo_empty = 1, trecieve = 1;
  logic [7:0] fifo_data = 0;
  logic       fifo_re, t0, t1, t2, t3, t4, t5, t6, t7, tsent, isFinish;
  logic [7:0] CRC;
  logic [3:0] byte_count, error;
  fifo_to_between #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .crc_clear(crc_clear), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_re(fifo_re), .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
    .t5(t5), .t6(t6), .t7(t7), .tsent(tsent), .trecieve(trecieve), .CRC(CRC),
    .byte_count(byte_count), .isFinish(isFinish), .error(error)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int fin_cnt = 0, re_cnt = 0, rx_mode = 0, dly = 0;
  bit fin_prev = 0, re_prev = 0, tsent_seen = 0, rand_en = 0;
  logic [7:0] q[$], exp_q[$];
  logic [7:0] m_crc = 0;
  logic [3:0] m_cnt = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    repeat (8) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
  function automatic logic [7:0] tbus();
    return {t0, t1, t2, t3, t4, t5, t6, t7};
  endfunction
  always @(posedge clk) begin
    #1;
    if (fifo_re && !re_prev && q.size() > 0) begin
      fifo_data = q.pop_front();
      re_cnt++;
    end
    re_prev = fifo_re;
    fifo_empty = (q.size() == 0);
  end
  always @(posedge clk) begin
    #2;
    if (tsent) begin
      tsent_seen = 1;
      if (exp_q.size() > 0) chk("t_stable", tbus(), exp_q[0]);
    end
    if (isFinish && !fin_prev) begin
      fin_cnt++;
      if (exp_q.size() == 0) chk("spurious_fin", 1, 0);
      else begin
        m_crc = crc_byte(m_crc, exp_q.pop_front());
        m_cnt++;
        chk("crc", CRC, m_crc);
        chk("count", byte_count, m_cnt);
      end
    end
    fin_prev = isFinish;
  end
  always @(posedge clk) begin
    #3;
    if (rx_mode == 0) begin
      if (tsent && trecieve) begin
        if (dly == 0) trecieve = 0;
        else dly--;
      end else if (!tsent && !trecieve) begin
        trecieve = 1;
        dly = $urandom_range(0, 3);
      end
    end
  end
  always @(posedge clk) begin
    #4;
    if (rand_en) enable = ($urandom_range(0, 7) != 0);
  end
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 0;
  endtask
  task automatic wait_fin(input int target, input int budget);
    int n = 0;
    while (fin_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #4;
    chk("fin_wait", fin_cnt >= target, 1);
  endtask
  task automatic lat_to_tsent(output int n);
    n = 0;
    while (!tsent && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    #3;
  endtask
  task automatic do_clear();
    crc_clear = 1;
    @(posedge clk);
    #4;
    crc_clear = 0;
    m_crc = 0;
    m_cnt = 0;
    chk("clr_crc", CRC, 0);
    chk("clr_cnt", byte_count, 0);
    chk("clr_err", error, 0);
  endtask
  int n, f0, r0;
  logic [7:0] crc_a;
  initial begin
    repeat (3) @(posedge clk);
    #4;
    chk("rst_re", fifo_re, 0);
    chk("rst_t", tbus(), 0);
    chk("rst_tsent", tsent, 0);
    chk("rst_crc", CRC, 0);
    chk("rst_cnt", byte_count, 0);
    chk("rst_fin", isFinish, 0);
    chk("rst_err", error, 0);
    reset = 1;
    repeat (4) @(posedge clk);
    #4;
    f0 = fin_cnt;
    r0 = re_cnt;
    push(8'h01);
    lat_to_tsent(n);
    chk("latency", n, 12);
    chk("t_01", tbus(), 8'h01);
    wait_fin(f0 + 1, 60);
    chk("crc_01", CRC, 8'h07);
    chk("cnt_01", byte_count, 1);
    repeat (5) @(posedge clk);
    #4;
    chk("one_fin", fin_cnt - f0, 1);
    push(8'h00);
    wait_fin(f0 + 2, 60);
    chk("crc_0100", CRC, 8'h15);
    chk("cnt_0100", byte_count, 2);
    repeat (5) @(posedge clk);
    #4;
    chk("re_pulses", re_cnt - r0, 2);
    do_clear();
    f0 = fin_cnt;
    tsent_seen = 0;
    push(8'hFF);
    wait_fin(f0 + 1, 60);
    chk("crc_ff", CRC, 8'hF3);
    chk("ff_sent", tsent_seen, 1);
    repeat (5) @(posedge clk);
    #4;
    f0 = fin_cnt;
    push(8'($urandom));
    n = 0;
    while (!tsent && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        #3;
        enable = 0;
        crc_a = CRC;
        #1;
      end
      if (n == 10) begin
        chk("stall_hold", CRC, crc_a);
        #3;
        enable = 1;
        #1;
      end
    end
    #3;
    chk("stall_latency", n, 17);
    wait_fin(f0 + 1, 60);
    repeat (5) @(posedge clk);
    #4;
    rx_mode = 1;
    trecieve = 0;
    repeat (4) @(posedge clk);
    #4;
    f0 = fin_cnt;
    tsent_seen = 0;
    push(8'($urandom));
    n = 0;
    while (error == 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    #3;
    chk("rdy_to_cycles", n, 27);
    chk("rdy_to_err", error, 4'b0001);
    chk("rdy_to_tsent", tsent_seen, 0);
    chk("rdy_to_cnt", byte_count, m_cnt);
    m_crc = crc_byte(m_crc, exp_q.pop_front());
    chk("rdy_to_crc", CRC, m_crc);
    repeat (2) @(posedge clk);
    #4;
    do_clear();
    rx_mode = 2;
    trecieve = 1;
    repeat (4) @(posedge clk);
    #4;
    push(8'($urandom));
    lat_to_tsent(n);
    #1;
    n = 0;
    while (tsent && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    #3;
    chk("cap_to_cycles", n, 16);
    chk("cap_to_err", error, 4'b0010);
    chk("cap_to_nofin", fin_cnt, f0);
    void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #4;
    do_clear();
    push(8'($urandom));
    lat_to_tsent(n);
    repeat (3) @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("arst_tsent", tsent, 0);
    chk("arst_t", tbus(), 0);
    chk("arst_re", fifo_re, 0);
    chk("arst_crc", CRC, 0);
    chk("arst_cnt", byte_count, 0);
    chk("arst_fin", isFinish, 0);
    chk("arst_err", error, 0);
    exp_q.delete();
    q.delete();
    m_crc = 0;
    m_cnt = 0;
    rx_mode = 0;
    @(posedge clk);
    #4;
    reset = 1;
    repeat (4) @(posedge clk);
    #4;
    f0 = fin_cnt;
    r0 = re_cnt;
    rand_en = 1;
    for (int i = 0; i < 20; i++) push(8'($urandom));
    wait_fin(f0 + 20, 4000);
    rand_en = 0;
    @(posedge clk);
    #4;
    enable = 1;
    repeat (5) @(posedge clk);
    #4;
    chk("rand_cnt_wrap", byte_count, 4'd4);
    chk("rand_re", re_cnt - r0, 20);
    chk("rand_err", error, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_to_between.md
Name: fifo_to_between

Overview:
Transmit side of the between-link. Pops bytes from the local FIFO and runs each byte MSB-first through a serial CRC-8. Drives the byte on t0..t7 and hands it over with the tsent/trecieve handshake that the receiving side uses. Keeps a running CRC over all bytes sent, and reports handshake timeouts.

Parameters:
TIMEOUT, 1024, cycles to wait for each trecieve edge before abort (≥2)
CNT_W, 16, width of the sent-byte counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset; reset==0 clears all state immediately
enable  input  1  FSM advances only when 1; when 0 all state and outputs hold
crc_clear  input  1  synchronous; clears CRC, byte_count and error (IDLE only, else ignored)
fifo_empty  input  1  source FIFO empty flag
fifo_data  input  8  FIFO read data, valid the cycle after fifo_re
fifo_re  output  1  one-cycle read strobe
t0..t7  output  1 each  link data; t0 = byte[7] ... t7 = byte[0]
tsent  output  1  data-valid strobe to receiver
trecieve  input  1  receiver ready (1) / captured (falls to 0)
CRC  output  8  running CRC-8 over all bytes sent since reset/clear
byte_count  output  CNT_W  bytes completed; wraps to 0 on overflow
isFinish  output  1  one-cycle pulse on byte completion
error  output  4  sticky: [0] ready timeout, [1] capture timeout, [3:2] always 0

Behaviour:
- Reset values: fifo_re=0, t0..t7=0, tsent=0, CRC=8'h00, byte_count=0, isFinish=0, error=0, state=IDLE.
- All outputs are registered. trecieve goes through a 2-flop synchronizer before the FSM uses it.
- CRC-8 uses poly 0x07 and init 0x00, serial MSB-first, no reflection, no final xor.
  - Per bit: fb = CRC[7]^bit; CRC = {CRC[6:0],1'b0} ^ (fb ? 8'h07 : 0).
- FSM states:
  - IDLE: tsent=0. If fifo_empty==0 → READ.
  - READ: fifo_re=1 for exactly one cycle → LATCH.
  - LATCH: fifo_re=0. Capture fifo_data into the byte register and drive t0..t7 from it. Bit index i=7 → CRC.
  - CRC: feed byte[i] each cycle, i decrements. After i==0 is fed (8 cycles) → WAIT_RDY.
  - WAIT_RDY: if synced trecieve==1 → SEND, tsent=1 next cycle; timer cleared.
  - SEND: hold tsent=1 and data stable. On synced trecieve==0 → DONE.
  - DONE: tsent=0, isFinish=1 for one cycle, byte_count+1 → IDLE.
- Latency: fifo_empty falls in IDLE → fifo_re in cycle 1 → data on t0..t7 from cycle 3 → tsent rises no earlier than cycle 12.
- Data stability: t0..t7 change only in LATCH, so they are stable at least 9 cycles before tsent rises and throughout SEND.
- Timeout: a counter runs in WAIT_RDY and in SEND.
  - On reaching TIMEOUT: set error[0] (WAIT_RDY) or error[1] (SEND), force tsent=0, → IDLE.
  - The byte is dropped: not counted, no isFinish. Its CRC contribution remains; the receiver must resync via crc_clear.
- enable=0 mid-transfer: everything freezes, including the timeout counter and CRC shifting. Resumes exactly where it stopped.
- Reset mid-operation: immediate return to reset values. A tsent that was high drops asynchronously.
- fifo_empty is only sampled in IDLE.
- crc_clear at the same time as the IDLE→READ transition: clear takes effect and the read proceeds.

Decomposition:
- Shared package between_link_pkg holds:
  - state enum (IDLE, READ, LATCH, CRC, WAIT_RDY, SEND, DONE)
  - CRC8_POLY=8'h07, CRC8_INIT=8'h00
  - error bit indices ERR_RDY_TO=0, ERR_CAP_TO=1
- One sub-module, crc8_serial (bit, en, clr, crc out; async active-low reset). It is shared with the receive side.

Test Plan:
- Single byte 0x01, receiver ready immediately → tsent high, t0..t6=0, t7=1, CRC=0x07, byte_count=1, one isFinish pulse.
- Bytes 0x01 then 0x00 → CRC=0x15 after second isFinish; byte_count=2; exactly two fifo_re pulses.
- Byte 0xFF after crc_clear → CRC=0xF3; t0..t7 all 1 for the whole SEND phase.
- trecieve held 0 with TIMEOUT=16 → error=4'b0001 after 16 WAIT_RDY cycles, tsent never rises, byte_count unchanged.
- trecieve rises then never falls → tsent=1 for 16 cycles, then 0; error[1]=1; no isFinish.
- reset pulsed low during SEND, and enable=0 for 5 cycles mid-CRC:
  - reset: tsent=0 and all outputs at reset values asynchronously.
  - enable stall: final CRC identical to the unstalled run; latency extended by exactly 5 cycles.
